truth_table_checker: RTL and testbench
======================================

TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4: clock cycles each input vector is held before the output is sampled; legal range 1..255.
REQ-002 Parameter EXPECTED, default 16'hAAEA: expected 1-bit result for each 4-bit input, where bit i is the response to input value i.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request to begin a sweep; level-sampled on the rising edge.
REQ-006 dut_in  output  4  vector driven to the stage under test; connects to that stage's sw[3:0].
REQ-007 dut_out  input  1  response of the stage under test (its led[0]); same clock domain, combinational from dut_in.
REQ-008 busy  output  1  high while a sweep is in progress.
REQ-009 done  output  1  high when a sweep has finished; held until the next accepted start.
REQ-010 pass  output  1  valid when done=1; 1 means all 16 vectors matched.
REQ-011 fail_index  output  4  valid when done=1 and pass=0; the first input value that mismatched. It SHALL be 0 when pass=1.

Function
REQ-012 The block SHALL implement four states: IDLE, DRIVE, SAMPLE and FIN.
REQ-013 In IDLE or FIN, start=1 at a rising edge SHALL:
  - move the block to DRIVE;
  - set the vector index to 0;
  - load the settle counter with SETTLE_CYCLES-1;
  - clear done, pass and fail_index.
REQ-014 In DRIVE or SAMPLE, start SHALL be ignored.
REQ-015 dut_in SHALL equal the registered vector index at all times; it SHALL NOT change in any state other than the SAMPLE-to-DRIVE transition and start acceptance.
REQ-016 Settle counter behaviour in DRIVE:
  - counter nonzero: decrement by 1 each cycle;
  - counter zero: move to SAMPLE.
  - DRIVE therefore lasts exactly SETTLE_CYCLES cycles.
REQ-017 SAMPLE SHALL last exactly one cycle and compare dut_out with EXPECTED[index] at its closing edge.
REQ-018 Mismatch in SAMPLE SHALL: move to FIN, set done=1, set pass=0, set fail_index=index. The sweep stops at the first mismatch.
REQ-019 Match in SAMPLE with index=15 SHALL: move to FIN, set done=1, set pass=1, set fail_index=0.
REQ-020 Match in SAMPLE with index<15 SHALL: increment index by 1 (4-bit, no wrap reachable), reload the settle counter, and return to DRIVE.
REQ-021 busy SHALL be 1 exactly when the state is DRIVE or SAMPLE.
REQ-022 Latency:
  - each vector occupies SETTLE_CYCLES+1 cycles;
  - a full passing sweep raises done 16*(SETTLE_CYCLES+1) cycles after the start-accept edge;
  - a failure at index k raises done (k+1)*(SETTLE_CYCLES+1) cycles after that edge.
REQ-023 In FIN, start=1 on any cycle SHALL restart per REQ-013 (back-to-back sweeps allowed). If start is held high continuously, a new sweep SHALL begin on the cycle after each FIN entry.

Reset
REQ-024 rst_n=0 SHALL immediately, without waiting for clk, force: state=IDLE, index=0, settle counter=0, dut_in=0, busy=0, done=0, pass=0, fail_index=0.
REQ-025 Asserting rst_n mid-sweep SHALL abort the sweep with no partial result retained.
REQ-026 After rst_n rises, the block SHALL remain in IDLE until start=1.

Verification
REQ-027 Model of the correct function (led = EXPECTED[sw]), SETTLE_CYCLES=4, one start pulse -> dut_in steps 0..15, each value held 5 cycles; busy high 80 cycles; then done=1, pass=1, fail_index=0.
REQ-028 dut_out stuck at 0 -> index 0 matches, index 1 mismatches; done=1 at 10 cycles, pass=0, fail_index=1.
REQ-029 Correct model except output inverted for input 9 -> done=1 at 50 cycles, pass=0, fail_index=9.
REQ-030 rst_n pulsed low while dut_in=7 -> all outputs 0 immediately. A subsequent start restarts from dut_in=0 and reaches pass=1.
REQ-031 start pulsed during busy -> no effect on the sweep. start asserted in FIN after a failure -> done, pass and fail_index clear on the next edge, and the new sweep begins.
REQ-032 SETTLE_CYCLES=1 with the correct model -> each vector held 2 cycles; done=1, pass=1 at 32 cycles.

Source files
------------

// File: rtl/truth_table_checker_if.sv
// Connection bundle between the truth-table checker and the stage under test.
//   start      : request to begin a sweep (from the controlling environment)
//   dut_in     : 4-bit vector driven to the stage under test (its sw[3:0])
//   dut_out    : 1-bit response of the stage under test (its led[0])
//   busy       : sweep in progress
//   done       : sweep finished, held until the next accepted start
//   pass       : all 16 vectors matched (valid with done)
//   fail_index : first mismatching vector (valid with done and !pass)
// master = checker side, slave = environment / stage-under-test side.
interface truth_table_checker_if;
  logic       start;
  logic [3:0] dut_in;
  logic       dut_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_index;

  modport master (
    input  start,
    input  dut_out,
    output dut_in,
    output busy,
    output done,
    output pass,
    output fail_index
  );

  modport slave (
    output start,
    output dut_out,
    input  dut_in,
    input  busy,
    input  done,
    input  pass,
    input  fail_index
  );
endinterface

// File: rtl/truth_table_checker.sv
// Exhaustive 4-input truth-table checker. On start it steps dut_in through
// 0..15, holds each vector SETTLE_CYCLES cycles, then compares dut_out with
// EXPECTED[vector] for one cycle. Stops at the first mismatch.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : truth_table_checker_if.master (start/dut_in/dut_out/
//                busy/done/pass/fail_index)
module truth_table_checker #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [15:0] EXPECTED      = 16'hAAEA
) (
  input  logic                   clk,
  input  logic                   rst_n,
  truth_table_checker_if.master  bus
);

  localparam int unsigned CNT_W    = 8;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned LAST_IDX = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    FIN    = 2'd3
  } state_t;

  state_t             state_q, state_n;
  logic [IDX_W-1:0]   idx_q, idx_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic               busy_q, busy_n;
  logic               done_q, done_n;
  logic               pass_q, pass_n;
  logic [IDX_W-1:0]   fidx_q, fidx_n;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fidx_q  <= '0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      cnt_q   <= cnt_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      pass_q  <= pass_n;
      fidx_q  <= fidx_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    cnt_n   = cnt_q;
    done_n  = done_q;
    pass_n  = pass_q;
    fidx_n  = fidx_q;

    unique case (state_q)
      IDLE, FIN: begin
        if (bus.start) begin
          state_n = DRIVE;
          idx_n   = '0;
          cnt_n   = CNT_W'(SETTLE_CYCLES - 1);
          done_n  = 1'b0;
          pass_n  = 1'b0;
          fidx_n  = '0;
        end
      end
      DRIVE: begin
        // Counter is loaded with SETTLE_CYCLES-1, so DRIVE spans SETTLE_CYCLES cycles
        if (cnt_q != '0) begin
          cnt_n = cnt_q - CNT_W'(1);
        end else begin
          state_n = SAMPLE;
        end
      end
      SAMPLE: begin
        if (bus.dut_out != EXPECTED[idx_q]) begin
          state_n = FIN;
          done_n  = 1'b1;
          pass_n  = 1'b0;
          fidx_n  = idx_q;
        end else if (idx_q == IDX_W'(LAST_IDX)) begin
          state_n = FIN;
          done_n  = 1'b1;
          pass_n  = 1'b1;
          fidx_n  = '0;
        end else begin
          state_n = DRIVE;
          idx_n   = idx_q + IDX_W'(1);
          cnt_n   = CNT_W'(SETTLE_CYCLES - 1);
        end
      end
      default: state_n = IDLE;
    endcase

    // busy is registered from the next state so it tracks DRIVE/SAMPLE exactly
    busy_n = (state_n == DRIVE) || (state_n == SAMPLE);
  end

  assign bus.dut_in     = idx_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.fail_index = fidx_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: table-driven directed sweeps, randomized
// response tables against a first-mismatch reference model, reset abort,
// held-start back-to-back sweeps, and a SETTLE_CYCLES=1 instance.
module tb_truth_table_checker;

  localparam logic [15:0] EXP = 16'hAAEA;
  localparam int          S0  = 4;
  localparam int          S1  = 1;

  logic        clk;
  logic        rst_n;
  logic [15:0] resp0;
  logic [15:0] resp1;

  int n_checks = 0;
  int n_fails  = 0;

  truth_table_checker_if bus0 ();
  truth_table_checker_if bus1 ();

  // Stage-under-test models: combinational lookup of the response table
  assign bus0.dut_out = resp0[bus0.dut_in];
  assign bus1.dut_out = resp1[bus1.dut_in];

  truth_table_checker #(.SETTLE_CYCLES(S0), .EXPECTED(EXP)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  truth_table_checker #(.SETTLE_CYCLES(S1), .EXPECTED(EXP)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] resp;
    int          cycles;
    logic        pass;
    logic [3:0]  fidx;
    int          glitch;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: the sweep stops at the first input whose response differs from EXP
  function automatic void model(input logic [15:0] r, output int cyc,
                                output logic p, output logic [3:0] f);
    int k;
    k = 16;
    for (int i = 15; i >= 0; i--)
      if (r[i] !== EXP[i]) k = i;
    p   = (k == 16);
    f   = p ? 4'd0 : 4'(k);
    cyc = p ? 16 * (S0 + 1) : (k + 1) * (S0 + 1);
  endfunction

  // One sweep on instance 0 with full per-cycle trace check.
  // glitch >= 0 pulses start while busy at that cycle offset.
  task automatic do_sweep(input string tag, input logic [15:0] r, input int exp_cyc,
                          input logic exp_pass, input logic [3:0] exp_fidx, input int glitch);
    int c;
    int errs;
    int first_bad;
    resp0      = r;
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    c = 0; errs = 0; first_bad = -1;
    while (c < exp_cyc) begin
      if (bus0.dut_in !== 4'(c / (S0 + 1)) || bus0.busy !== 1'b1 || bus0.done !== 1'b0 ||
          bus0.pass !== 1'b0 || bus0.fail_index !== 4'd0) begin
        errs++;
        if (first_bad < 0) first_bad = c;
      end
      bus0.start = (c == glitch);
      @(negedge clk);
      c++;
    end
    bus0.start = 1'b0;
    chk({tag, " trace_errs(first_bad_cycle)"}, 32'(errs), 32'd0);
    if (errs != 0) $display("  first bad cycle %0d", first_bad);
    chk({tag, " done"},       32'(bus0.done), 32'd1);
    chk({tag, " busy"},       32'(bus0.busy), 32'd0);
    chk({tag, " pass"},       32'(bus0.pass), 32'(exp_pass));
    chk({tag, " fail_index"}, 32'(bus0.fail_index), 32'(exp_fidx));
    chk({tag, " dut_in_fin"}, 32'(bus0.dut_in), exp_pass ? 32'd15 : 32'(exp_fidx));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " dut_in"},     32'(bus0.dut_in), 32'd0);
    chk({tag, " busy"},       32'(bus0.busy), 32'd0);
    chk({tag, " done"},       32'(bus0.done), 32'd0);
    chk({tag, " pass"},       32'(bus0.pass), 32'd0);
    chk({tag, " fail_index"}, 32'(bus0.fail_index), 32'd0);
  endtask

  initial begin
    vec_t        tbl[4];
    logic [15:0] r;
    int          cyc;
    logic        p;
    logic [3:0]  f;
    int          n;
    int          errs;

    // Directed vectors: correct, stuck-at-0, input 9 inverted, then restart after failure
    tbl[0] = '{resp: EXP,              cycles: 80, pass: 1'b1, fidx: 4'd0, glitch: -1};
    tbl[1] = '{resp: 16'h0000,         cycles: 10, pass: 1'b0, fidx: 4'd1, glitch: -1};
    tbl[2] = '{resp: EXP ^ 16'h0200,   cycles: 50, pass: 1'b0, fidx: 4'd9, glitch: 23};
    tbl[3] = '{resp: EXP,              cycles: 80, pass: 1'b1, fidx: 4'd0, glitch: 7};

    rst_n      = 1'b0;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    resp0      = EXP;
    resp1      = EXP;

    @(negedge clk);
    chk_zero("reset");
    chk("reset inst1 busy", 32'(bus1.busy), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("idle_after_reset");

    foreach (tbl[i])
      do_sweep($sformatf("table%0d", i), tbl[i].resp, tbl[i].cycles,
               tbl[i].pass, tbl[i].fidx, tbl[i].glitch);

    // Randomized response tables against the reference model
    for (int it = 0; it < 12; it++) begin
      case ($urandom_range(0, 2))
        0:       r = EXP;
        1:       r = EXP ^ (16'h0001 << $urandom_range(0, 15));
        default: r = 16'($urandom);
      endcase
      model(r, cyc, p, f);
      do_sweep($sformatf("rand%0d", it), r, cyc, p, f,
               ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, cyc - 1)) : -1);
    end

    // Reset mid-sweep while vector 7 is applied
    resp0      = EXP;
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    repeat (7 * (S0 + 1) + 2) @(negedge clk);
    chk("pre_reset dut_in", 32'(bus0.dut_in), 32'd7);
    #1 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("post_reset_idle");
    do_sweep("after_reset", EXP, 80, 1'b1, 4'd0, -1);

    // start held high: new sweep begins the cycle after FIN entry
    resp0      = 16'h0000;
    bus0.start = 1'b1;
    @(negedge clk);
    repeat (10) @(negedge clk);
    chk("held done",       32'(bus0.done), 32'd1);
    chk("held fail_index", 32'(bus0.fail_index), 32'd1);
    @(negedge clk);
    bus0.start = 1'b0;
    chk("held restart busy",  32'(bus0.busy), 32'd1);
    chk("held restart done",  32'(bus0.done), 32'd0);
    chk("held restart fidx",  32'(bus0.fail_index), 32'd0);
    chk("held restart dutin", 32'(bus0.dut_in), 32'd0);
    n = 0;
    while (bus0.done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("held second sweep cycles", 32'(n), 32'd10);

    // SETTLE_CYCLES=1 instance: 2 cycles per vector, 32 cycles total
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    n = 0; errs = 0;
    while (bus1.done !== 1'b1 && n < 200) begin
      if (bus1.dut_in !== 4'(n / (S1 + 1)) || bus1.busy !== 1'b1) errs++;
      @(negedge clk);
      n++;
    end
    chk("s1 trace_errs", 32'(errs), 32'd0);
    chk("s1 cycles",     32'(n), 32'd32);
    chk("s1 pass",       32'(bus1.pass), 32'd1);
    chk("s1 fail_index", 32'(bus1.fail_index), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
